serial_subtractor_nbit: RTL and testbench

- Parameterized, bit-serial subtractor. Computes diff = a - b - borrow_in one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake.
- Acts as the area-lean inverse-arithmetic companion to the combinational ripple adders in the datapath. Sits between operand registers and the result bus where latency is acceptable.

---
 rtl/serial_subtractor_nbit_if.sv | 31 +++
 rtl/serial_subtractor_nbit.sv | 138 +++++++++++++
 tb/tb_serial_subtractor_nbit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_nbit_if.sv
// ============================================================================
// Module      : serial_subtractor_nbit_if
// Description : Handshake and operand/result bundle for serial_subtractor_nbit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_nbit_if #(
    parameter int NUM_BITS = 4
);
    logic                start;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                borrow_in;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] diff;
    logic                underflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, underflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, underflow
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor_nbit.sv
// ============================================================================
// Module      : serial_subtractor_nbit
// Description : Bit-serial a - b - borrow_in, LSB first, one full-subtractor
//               cell plus a borrow flop, start/busy/done handshake.
//               Optional macro SERIAL_SUB_SELF_CHECK_EN adds simulation-only
//               result assertions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_nbit #(
    parameter int NUM_BITS = 4
) (
    input  wire logic                  clk,
    input  wire logic                  n_rst,
    serial_subtractor_nbit_if.slave    bus
);

    localparam int               C_CNT_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [NUM_BITS-1:0]  r_a;
    logic [NUM_BITS-1:0]  r_b;
    logic [NUM_BITS-1:0]  r_res;
    logic                 r_br;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [NUM_BITS-1:0]  r_diff;
    logic                 r_uf;

    logic                 w_a_bit;
    logic                 w_b_bit;
    logic                 w_d;
    logic                 w_br_next;
    logic [NUM_BITS-1:0]  w_res_full;

    assign w_a_bit   = r_a[r_cnt];
    assign w_b_bit   = r_b[r_cnt];
    assign w_d       = w_a_bit ^ w_b_bit ^ r_br;
    assign w_br_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);

    // Result including the bit being processed this cycle, so the final
    // edge can publish the complete word directly.
    always_comb begin
        w_res_full        = r_res;
        w_res_full[r_cnt] = w_d;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_uf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_br    <= bus.borrow_in;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_res <= w_res_full;
                    r_br  <= w_br_next;
                    if (r_cnt == C_LAST_BIT) begin
                        r_diff  <= w_res_full;
                        r_uf    <= w_br_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.diff      = r_diff;
    assign bus.underflow = r_uf;

`ifdef SERIAL_SUB_SELF_CHECK_EN
    // The borrow flop is consumed during the operation, so keep a copy of
    // the captured borrow for the end-of-operation check.
    logic r_bin_cap;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_bin_cap <= 1'b0;
        end else if (bus.start && (r_state != ST_BUSY)) begin
            r_bin_cap <= bus.borrow_in;
        end
    end

    always @(posedge clk) begin
        if (n_rst && r_done) begin
            assert ({r_uf, r_diff} ==
                    ({1'b0, r_a} - {1'b0, r_b} - {{NUM_BITS{1'b0}}, r_bin_cap}))
            else $error("serial subtractor result mismatch");
        end
        assert (!(r_busy && r_done))
        else $error("serial subtractor busy and done both high");
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_nbit.sv
// ============================================================================
// Module      : tb_serial_subtractor_nbit
// Description : Directed and random self-checking bench for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor_nbit;

    localparam int NUM_BITS = 4;

    logic clk;
    logic n_rst;
    int   total;
    int   bad;

    serial_subtractor_nbit_if #(.NUM_BITS(NUM_BITS)) bus ();

    serial_subtractor_nbit #(.NUM_BITS(NUM_BITS)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation and follows it to its done pulse (bounded).
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output logic [4:0] res, output int bcnt, output bit got);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.borrow_in = bin;
        @(negedge clk);
        bus.start = 1'b0;
        bcnt = 0;
        got  = 1'b0;
        res  = '0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                res = {bus.underflow, bus.diff};
                break;
            end
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        n_rst         = 1'b0;
        bus.start     = 1'b1;
        bus.a         = 4'd5;
        bus.b         = 4'd1;
        bus.borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.underflow, bus.diff} !== 7'd0) begin
            bad++;
            $display("FAIL reset_state: got %b expected 0000000",
                     {bus.busy, bus.done, bus.underflow, bus.diff});
        end
        bus.start = 1'b0;
        n_rst     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({bus.busy, bus.done, bus.underflow, bus.diff} !== 7'd0) begin
                bad++;
                $display("FAIL idle_cycle%0d: got %b expected 0000000", i,
                         {bus.busy, bus.done, bus.underflow, bus.diff});
            end
        end
    endtask

    task automatic test_basic;
        logic [4:0] res;
        int         bcnt;
        bit         got;
        do_op(4'd7, 4'd3, 1'b0, res, bcnt, got);
        total++;
        if (!got || res !== 5'b0_0100 || bcnt != 4) begin
            bad++;
            $display("FAIL basic_7m3: got done=%0d res=%b busy_cycles=%0d expected done=1 res=00100 busy_cycles=4",
                     got, res, bcnt);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.diff !== 4'd4 || bus.underflow !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: got done=%b diff=%0d uf=%b expected done=0 diff=4 uf=0",
                     bus.done, bus.diff, bus.underflow);
        end
    endtask

    task automatic test_underflow;
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vc [3];
        logic [4:0] ve [3];
        logic [4:0] res;
        int         bcnt;
        bit         got;
        va[0] = 4'd0;  vb[0] = 4'd0;  vc[0] = 1'b1; ve[0] = 5'b1_1111;
        va[1] = 4'd15; vb[1] = 4'd15; vc[1] = 1'b0; ve[1] = 5'b0_0000;
        va[2] = 4'd3;  vb[2] = 4'd5;  vc[2] = 1'b0; ve[2] = 5'b1_1110;
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], vc[k], res, bcnt, got);
            total++;
            if (!got || res !== ve[k]) begin
                bad++;
                $display("FAIL underflow_vec%0d: got done=%0d res=%b expected done=1 res=%b",
                         k, got, res, ve[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        int cyc;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = 4'd10;
        bus.b         = 4'd4;
        bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.a = 4'd9;
        bus.b = 4'd1;
        total++;
        if (bus.busy !== 1'b1 || bus.diff !== 4'd14 || bus.underflow !== 1'b1) begin
            bad++;
            $display("FAIL hold_during_busy: got busy=%b diff=%0d uf=%b expected busy=1 diff=14 uf=1",
                     bus.busy, bus.diff, bus.underflow);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen || {bus.underflow, bus.diff} !== 5'b0_0110) begin
            bad++;
            $display("FAIL start_held_10m4: got done=%0d res=%b expected done=1 res=00110",
                     seen, {bus.underflow, bus.diff});
        end
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_bubble: got busy=%b done=%b expected busy=1 done=0",
                     bus.busy, bus.done);
        end
        cyc  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) cyc++;
        end
        total++;
        if (!seen || {bus.underflow, bus.diff} !== 5'b0_1000 || cyc != 4) begin
            bad++;
            $display("FAIL b2b_9m1: got done=%0d res=%b busy_cycles=%0d expected done=1 res=01000 busy_cycles=4",
                     seen, {bus.underflow, bus.diff}, cyc);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = 4'd12;
        bus.b         = 4'd2;
        bus.borrow_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: got busy=%b expected 1", bus.busy);
        end
        n_rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.underflow, bus.diff} !== 7'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b expected 0000000",
                     {bus.busy, bus.done, bus.underflow, bus.diff});
        end
        n_rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", dones);
        end
    endtask

    task automatic test_random;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic [4:0] exp_res;
        logic [4:0] res;
        int         bcnt;
        bit         got;
        for (int n = 0; n < 500; n++) begin
            ra      = 4'($urandom_range(0, 15));
            rb      = 4'($urandom_range(0, 15));
            rc      = 1'($urandom_range(0, 1));
            exp_res = {1'b0, ra} - {1'b0, rb} - {4'b0000, rc};
            do_op(ra, rb, rc, res, bcnt, got);
            total++;
            if (!got || res !== exp_res || bcnt != 4) begin
                bad++;
                $display("FAIL random_%0d a=%0d b=%0d bin=%0d: got done=%0d res=%b busy_cycles=%0d expected res=%b busy_cycles=4",
                         n, ra, rb, rc, got, res, bcnt, exp_res);
            end
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        n_rst         = 1'b0;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
